// File: rtl/dm_store_arb.sv
// ============================================================================
// Module   : dm_store_arb
// Purpose  : Two-requester store arbiter in front of a single data-memory
//            write port. A round-robin pointer picks between two requesters
//            when both are valid. The winner's sb/sh/sw store is lane-placed
//            into a registered memory write that is held until mem_ready.
//            A wait counter aborts the write after TIMEOUT_CYC cycles.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous, active-low reset
//            reqN_valid/_ready/_addr/_data/_op (N=0,1) - store requests
//            mem_we/mem_byteen/mem_addr/mem_wdata - registered memory write
//            mem_ready      - memory accepts the write on this edge
//            err            - one-cycle pulse on timeout or rejected request
//            grant_id       - requester owning the current transaction
// Config   : DM_STORE_ARB_ALIGN_CHK_EN - when defined, a misaligned sh or sw
//            is consumed without a write and raises err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_store_arb #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_data,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_data,
  input  logic [2:0]  req1_op,
  output logic        mem_we,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        err,
  output logic        grant_id
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [8:0] C_TO_LIMIT = 9'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        grant_q, grant_d;

  logic        w_sel;
  logic        w_accept;
  logic [2:0]  w_op;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_store;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [8:0]  w_cnt_inc;

  // A lone valid requester wins; on contention the round-robin pointer decides.
  assign w_sel    = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign w_accept = (state_q == ST_IDLE) && (req0_valid || req1_valid);

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !w_sel;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  w_sel;

  assign w_op   = w_sel ? req1_op   : req0_op;
  assign w_addr = w_sel ? req1_addr : req0_addr;
  assign w_data = w_sel ? req1_data : req0_data;

  assign w_store   = (w_op == 3'd1) || (w_op == 3'd2) || (w_op == 3'd3);
  assign w_cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef DM_STORE_ARB_ALIGN_CHK_EN
  assign w_misalign = ((w_op == 3'd2) && w_addr[0]) ||
                      ((w_op == 3'd3) && (w_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Lane placement of right-aligned store data; unused lanes stay zero.
  always_comb begin
    w_be = 4'b0000;
    w_wd = 32'h0;
    case (w_op)
      3'd1: begin
        w_be = 4'b0001 << w_addr[1:0];
        w_wd = {24'h0, w_data[7:0]} << {w_addr[1:0], 3'b000};
      end
      3'd2: begin
        if (w_addr[1]) begin
          w_be = 4'b1100;
          w_wd = {w_data[15:0], 16'h0};
        end else begin
          w_be = 4'b0011;
          w_wd = {16'h0, w_data[15:0]};
        end
      end
      3'd3: begin
        w_be = 4'b1111;
        w_wd = w_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          rr_d    = ~w_sel;
          grant_d = w_sel;
          if (w_store && !w_misalign) begin
            state_d = ST_BUSY;
            we_d    = 1'b1;
            be_d    = w_be;
            wd_d    = w_wd;
            addr_d  = w_addr;
            cnt_d   = 8'd0;
          end else begin
            // Non-store ops are silently consumed; misaligned ones flag err.
            err_d = w_misalign;
          end
        end
      end
      ST_BUSY: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (mem_ready) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          wd_d    = 32'h0;
          cnt_d   = 8'd0;
        end else if (w_cnt_inc >= C_TO_LIMIT) begin
          state_d = ST_IDLE;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          wd_d    = 32'h0;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = w_cnt_inc[7:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      addr_q  <= 32'h0;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      grant_q <= grant_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_byteen = be_q;
  assign mem_wdata  = wd_q;
  assign mem_addr   = addr_q;
  assign err        = err_q;
  assign grant_id   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_store_arb.sv
// ============================================================================
// Module   : tb_dm_store_arb
// Purpose  : Self-checking bench for dm_store_arb with directed scenarios and
//            randomized transactions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_store_arb;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
  logic [2:0]  req0_op, req1_op;
  logic        mem_we;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic        err;
  logic        grant_id;

  int   checks = 0;
  int   errors = 0;
  logic rr_m;

  dm_store_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_op    (req1_op),
    .mem_we     (mem_we),
    .mem_byteen (mem_byteen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .err        (err),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {byteen, wdata} from the store rules, by plain arithmetic.
  function automatic logic [35:0] lanes(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [31:0] data);
    int          off;
    logic [3:0]  be;
    logic [31:0] wd;
    be = 4'h0;
    wd = 32'h0;
    if (op == 3'd1) begin
      off = int'(addr % 4);
      be  = 4'(1 << off);
      wd  = (data & 32'hFF) << (8 * off);
    end else if (op == 3'd2) begin
      off = int'((addr / 2) % 2) * 2;
      be  = 4'(3 << off);
      wd  = (data & 32'hFFFF) << (8 * off);
    end else if (op == 3'd3) begin
      be = 4'hF;
      wd = data;
    end
    return {be, wd};
  endfunction

  function automatic bit misaligned(input logic [2:0] op, input logic [31:0] addr);
`ifdef DM_STORE_ARB_ALIGN_CHK_EN
    return ((op == 3'd2) && (addr % 2 != 0)) || ((op == 3'd3) && (addr % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 32'h0; req1_addr = 32'h0;
    req0_data = 32'h0; req1_data = 32'h0;
    req0_op = 3'd0; req1_op = 3'd0;
    mem_ready = 1'b0;
  endtask

  // One full transaction from IDLE: present requests, accept, then hold
  // mem_ready low for 'delay' BUSY cycles (timeout may come first).
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [2:0] op0, input logic [2:0] op1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int delay, input string tag);
    logic        w;
    logic [2:0]  op;
    logic [31:0] a, d;
    logic [35:0] ln;
    bit          wr, mis, done, completed;
    int          c;
    req0_valid = v0; req0_op = op0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_op = op1; req1_addr = a1; req1_data = d1;
    mem_ready = 1'b0;
    w = (v0 && v1) ? rr_m : v1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== {v0 && !w, v1 && w}) begin
      errors++;
      $display("FAIL %s ready: got %b required %b", tag, {req0_ready, req1_ready},
               {v0 && !w, v1 && w});
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    op = w ? op1 : op0;
    a  = w ? a1 : a0;
    d  = w ? d1 : d0;
    rr_m = ~w;
    ln  = lanes(op, a, d);
    mis = misaligned(op, a);
    wr  = (op >= 3'd1) && (op <= 3'd3) && !mis;
    if (wr) begin
      c = 0;
      done = 1'b0;
      completed = 1'b0;
      while (!done) begin
        checks++;
        if ({mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id} !==
            {1'b1, ln, a, 1'b0, w}) begin
          errors++;
          $display("FAIL %s busy c%0d: got %h required %h", tag, c,
                   {mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id},
                   {1'b1, ln, a, 1'b0, w});
        end
        completed = (c >= delay);
        mem_ready = completed;
        done = completed || (c + 1 >= TO);
        tick();
        c++;
      end
      mem_ready = 1'b0;
      checks++;
      if ({mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id} !==
          {1'b0, 4'h0, 32'h0, a, !completed, w}) begin
        errors++;
        $display("FAIL %s end: got %h required %h", tag,
                 {mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id},
                 {1'b0, 4'h0, 32'h0, a, !completed, w});
      end
    end else begin
      checks++;
      if ({mem_we, mem_byteen, mem_wdata, err, grant_id} !== {1'b0, 4'h0, 32'h0, mis, w}) begin
        errors++;
        $display("FAIL %s nowrite: got %h required %h", tag,
                 {mem_we, mem_byteen, mem_wdata, err, grant_id}, {1'b0, 4'h0, 32'h0, mis, w});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if ({mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id, req0_ready, req1_ready} !== 73'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0",
               {mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id, req0_ready, req1_ready});
    end
    tick();
    reset = 1'b1;
    rr_m = 1'b0;
    tick();
  endtask

  task automatic test_sb_directed();
    req0_valid = 1'b1; req0_op = 3'd1; req0_addr = 32'h1002; req0_data = 32'hAB;
    mem_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({mem_we, mem_byteen, mem_wdata, mem_addr} !== {1'b1, 4'b0100, 32'h00AB0000, 32'h1002}) begin
      errors++;
      $display("FAIL sb_write: got %h required %h", {mem_we, mem_byteen, mem_wdata, mem_addr},
               {1'b1, 4'b0100, 32'h00AB0000, 32'h1002});
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({mem_we, mem_byteen, mem_wdata, err} !== 38'h0) begin
      errors++;
      $display("FAIL sb_done: got %h required 0", {mem_we, mem_byteen, mem_wdata, err});
    end
    rr_m = 1'b1;
    run_txn(1, 0, 3'd1, 3'd0, 32'h1003, 32'h0, 32'h5A, 32'h0, 0, "sb_lane3");
  endtask

  task automatic test_round_robin();
    rr_m = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    run_txn(1, 1, 3'd3, 3'd3, 32'h100, 32'h200, 32'h11111111, 32'h22222222, 0, "rr_first");
    run_txn(1, 1, 3'd3, 3'd3, 32'h100, 32'h200, 32'h11111111, 32'h22222222, 0, "rr_second");
  endtask

  task automatic test_back_pressure();
    run_txn(0, 1, 3'd0, 3'd2, 32'h0, 32'h2002, 32'h0, 32'h1234BEEF, 3, "sh_hold");
    run_txn(1, 0, 3'd2, 3'd0, 32'h2000, 32'h0, 32'hCAFEF00D, 32'h0, 1, "sh_low");
  endtask

  task automatic test_timeout();
    run_txn(1, 0, 3'd3, 3'd0, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0, 100, "timeout");
    run_txn(0, 1, 3'd1, 3'd1, 32'h0, 32'h41, 32'h0, 32'h77, 0, "after_timeout");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_single_pulse: got %b required 0", err);
    end
    run_txn(1, 0, 3'd3, 3'd0, 32'h44, 32'h0, 32'h12345678, 32'h0, TO - 1, "ready_at_timeout");
  endtask

  task automatic test_reset_busy();
    req0_valid = 1'b1; req0_op = 3'd3; req0_addr = 32'h80; req0_data = 32'hFFFF0000;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: got %b required 1", mem_we);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id} !== 71'h0) begin
      errors++;
      $display("FAIL rst_busy_async: got %h required 0",
               {mem_we, mem_byteen, mem_wdata, mem_addr, err, grant_id});
    end
    #1;
    reset = 1'b1;
    rr_m = 1'b0;
    tick();
    run_txn(1, 1, 3'd3, 3'd1, 32'h90, 32'h91, 32'hA5A5A5A5, 32'h3C, 0, "rst_rr0");
  endtask

  task automatic test_align();
    run_txn(1, 0, 3'd3, 3'd0, 32'h3001, 32'h0, 32'h01020304, 32'h0, 0, "sw_3001");
    run_txn(0, 1, 3'd0, 3'd2, 32'h0, 32'h3003, 32'h0, 32'h0000ABCD, 0, "sh_3003");
    run_txn(1, 0, 3'd0, 3'd0, 32'h10, 32'h0, 32'h99, 32'h0, 0, "op_none");
  endtask

  task automatic test_random();
    logic v0, v1;
    int   dly;
    for (int i = 0; i < 150; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      dly = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, TO));
      run_txn(v0, v1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, $urandom, dly, "random");
    end
  endtask

  initial begin
    rr_m = 1'b0;
    test_reset();
    test_sb_directed();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_reset_busy();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_store_arb.md
DM_STORE_ARB -- requirements
Module: dm_store_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15: maximum cycles the memory write is held awaiting mem_ready before abort (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports reqN_valid  input  1  request valid, for N=0,1.
REQ-005 SHALL have ports reqN_ready  output  1  request accepted this cycle, for N=0,1.
REQ-006 SHALL have ports reqN_addr  input  32  byte address, for N=0,1.
REQ-007 SHALL have ports reqN_data  input  32  store data, right-aligned, for N=0,1.
REQ-008 SHALL have ports reqN_op  input  3  store op (1 sb, 2 sh, 3 sw, other none), for N=0,1.
REQ-009 SHALL have port mem_we  output  1  write strobe to data memory.
REQ-010 SHALL have port mem_byteen  output  4  byte lane enables.
REQ-011 SHALL have port mem_addr  output  32  request address, passed unmodified.
REQ-012 SHALL have port mem_wdata  output  32  lane-placed write data.
REQ-013 SHALL have port mem_ready  input  1  memory accepts the write on this edge.
REQ-014 SHALL have port err  output  1  one-cycle pulse on timeout or rejected request.
REQ-015 SHALL have port grant_id  output  1  requester owning the current transaction.

Function
REQ-016 SHALL implement states IDLE and BUSY; every output register SHALL be registered.
REQ-017 In IDLE, reqN_ready SHALL be 1 only for the requester selected by arbitration and only while that requester's valid is 1; in BUSY, both ready SHALL be 0.
REQ-018 Arbitration: a single valid requester wins; if both are valid, the requester named by round-robin pointer rr wins.
REQ-019 rr SHALL be set to the other requester on each accepted request.
REQ-020 On acceptance (valid&ready) with op 1/2/3, next cycle SHALL enter BUSY with mem_we=1 and byteen/wdata/addr latched; latency request-to-mem_we is exactly 1 cycle.
REQ-021 sb lanes: addr[1:0]=0..3 -> byteen 0001/0010/0100/1000; data[7:0] placed in the selected byte.
REQ-022 sh lanes: addr[1]=0 -> 0011, data[15:0] in wdata[15:0]; addr[1]=1 -> 1100, data[15:0] in wdata[31:16].
REQ-023 sw: byteen 1111, wdata=data.
REQ-024 Unselected wdata bits SHALL be 0.
REQ-025 An accepted op of 0 or 4..7 SHALL be consumed with no write and no error; state remains IDLE.
REQ-026 In BUSY, outputs SHALL hold stable until mem_ready=1 is sampled.
REQ-027 On that edge, mem_we, byteen and wdata SHALL clear to 0, state returns to IDLE, and a new request may be accepted the following cycle.
REQ-028 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready.
REQ-029 On reaching TIMEOUT_CYC, the write SHALL be aborted: mem_we clears, err pulses for 1 cycle, state returns to IDLE.
REQ-030 If mem_ready and timeout occur on the same edge, completion SHALL win with no err.
REQ-031 grant_id SHALL update on acceptance and hold through BUSY.

Reset
REQ-032 Reset asserted at any time, including mid-BUSY, SHALL immediately force state IDLE, rr=0, counter=0, mem_we=0, mem_byteen=0, mem_wdata=0, mem_addr=0, err=0, grant_id=0; any in-flight write is dropped.
REQ-033 After reset release, req0 SHALL win the first simultaneous request.

Configuration
REQ-034 With macro DM_STORE_ARB_ALIGN_CHK_EN defined, an accepted sh with addr[0]=1 or sw with addr[1:0]!=0 SHALL be consumed without a write, and err SHALL pulse 1 cycle after acceptance.
REQ-035 Without DM_STORE_ARB_ALIGN_CHK_EN, addr[0] for sh and addr[1:0] for sw SHALL be ignored, and err SHALL come only from timeout.

Verification
REQ-036 req0 sb addr=0x1002 data=0xAB, mem_ready=1 -> next cycle mem_we=1, byteen=0100, wdata=0x00AB0000, addr=0x1002; IDLE one cycle later.
REQ-037 Both valid after reset, each sw (req0 data 0x11111111, req1 data 0x22222222), mem_ready=1 -> writes in order req0 then req1; grant_id 0 then 1.
REQ-038 req1 sh addr=0x2002 data=0x1234BEEF, mem_ready low 3 cycles then high -> byteen=1100, wdata=0xBEEF0000 stable for 4 cycles; no err.
REQ-039 TIMEOUT_CYC=4, mem_ready held 0 -> mem_we high 4 cycles, then drops with a single err pulse; the next request is accepted.
REQ-040 Reset asserted during BUSY -> mem_we falls asynchronously, all outputs 0; after release, req0 wins a simultaneous request.
REQ-041 With DM_STORE_ARB_ALIGN_CHK_EN, sw addr=0x3001 -> no mem_we, err pulse; without the macro -> byteen=1111, addr=0x3001.
